// File: rtl/celda_tipica_der_izq_pkg.sv
// Shared definitions for the right-to-left magnitude comparator cell.
// State a (A >= B so far) is 1, state b (A < B so far) is 0.
package celda_cmp_pkg;

   localparam logic ST_A = 1'b1;
   localparam logic ST_B = 1'b0;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_t;

   // A bit pair that differs decides the state; an equal pair keeps it.
   function automatic logic next_state(input logic p, input logic ai, input logic bi);
      return (ai & ~bi) | (p & ~(ai ^ bi));
   endfunction

endpackage

// File: rtl/celda_tipica_der_izq_if.sv
// Request/response bundle of the serial comparison engine.
// With CELDA_PARALLEL_CHAIN_EN defined it also carries result_comb.
interface celda_tipica_der_izq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_word;
   logic [WIDTH-1:0] b_word;
   logic             busy;
   logic             done;
   logic             result;
`ifdef CELDA_PARALLEL_CHAIN_EN
   logic             result_comb;
`endif

   modport master (
      output start, a_word, b_word,
`ifdef CELDA_PARALLEL_CHAIN_EN
      input  result_comb,
`endif
      input  busy, done, result
   );

   modport slave (
      input  start, a_word, b_word,
`ifdef CELDA_PARALLEL_CHAIN_EN
      output result_comb,
`endif
      output busy, done, result
   );
endinterface

// File: rtl/celda_tipica_der_izq_cmp_bit.sv
// One combinational comparator cell: present state plus one bit of A and B
// give the next state. Has no clock and no reset.
module celda_cmp_bit
   import celda_cmp_pkg::*;
(
   input  logic p,
   input  logic ai,
   input  logic bi,
   output logic pn
);

   assign pn = next_state(p, ai, bi);

endmodule

// File: rtl/celda_tipica_der_izq.sv
// Typical right-to-left comparator cell plus a serial engine that walks a
// WIDTH-bit word pair LSB first and reports A >= B.
// Optional macro CELDA_PARALLEL_CHAIN_EN adds a combinational chain of
// WIDTH cells driving bus.result_comb from the live words.
module celda_tipica_der_izq
   import celda_cmp_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter logic INIT_STATE = ST_A
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p,
   input  logic                  Ai,
   input  logic                  Bi,
   output logic                  P,
   celda_tipica_der_izq_if.slave bus
);

   localparam int             IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0]  LAST_IDX = IW'(WIDTH - 1);

   // Free-standing cell exposed for external iterative networks.
   celda_cmp_bit u_cell (
      .p  (p),
      .ai (Ai),
      .bi (Bi),
      .pn (P)
   );

   fsm_t             fsm_q, fsm_d;
   logic             st_q, st_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             busy_q, busy_d;
   logic             res_q, res_d;
   logic             last_q, last_d;
   logic             done_q, done_d;
   logic             st_nx;

   // Serial datapath: the same cell applied to the current bit position.
   celda_cmp_bit u_ser (
      .p  (st_q),
      .ai (a_q[idx_q]),
      .bi (b_q[idx_q]),
      .pn (st_nx)
   );

   // Next-state logic: accept in IDLE, one bit per cycle in RUN.
   // done trails the final bit by one cycle through last_q.
   always_comb begin
      fsm_d  = fsm_q;
      st_d   = st_q;
      idx_d  = idx_q;
      a_d    = a_q;
      b_d    = b_q;
      busy_d = busy_q;
      res_d  = res_q;
      last_d = 1'b0;
      done_d = last_q;
      case (fsm_q)
         IDLE: begin
            if (bus.start) begin
               a_d    = bus.a_word;
               b_d    = bus.b_word;
               st_d   = INIT_STATE;
               idx_d  = '0;
               fsm_d  = RUN;
               busy_d = 1'b1;
            end
         end
         RUN: begin
            st_d = st_nx;
            if (idx_q == LAST_IDX) begin
               res_d  = st_nx;
               fsm_d  = IDLE;
               busy_d = 1'b0;
               last_d = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any compare in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q  <= IDLE;
         st_q   <= INIT_STATE;
         idx_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         busy_q <= 1'b0;
         res_q  <= INIT_STATE;
         last_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         st_q   <= st_d;
         idx_q  <= idx_d;
         a_q    <= a_d;
         b_q    <= b_d;
         busy_q <= busy_d;
         res_q  <= res_d;
         last_q <= last_d;
         done_q <= done_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = res_q;

`ifdef CELDA_PARALLEL_CHAIN_EN
   logic [WIDTH:0] chain;

   assign chain[0] = INIT_STATE;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      celda_cmp_bit u_bit (
         .p  (chain[i]),
         .ai (bus.a_word[i]),
         .bi (bus.b_word[i]),
         .pn (chain[i+1])
      );
   end

   assign bus.result_comb = chain[WIDTH];
`endif

endmodule

// File: tb/tb_celda_tipica_der_izq.sv
// Bench for celda_tipica_der_izq: exhaustive cell check, directed and random
// serial compares scored against plain (a >= b) through an expected queue.
module tb_celda_tipica_der_izq;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   logic p, Ai, Bi, P;

   celda_tipica_der_izq_if #(.WIDTH(W)) bus ();

   celda_tipica_der_izq #(.WIDTH(W), .INIT_STATE(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .p   (p),
      .Ai  (Ai),
      .Bi  (Bi),
      .P   (P),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic exp;
      int   scyc;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("result", 32'(bus.result), 32'(e.exp));
            check("latency", 32'(cyc - e.scyc), 32'(W + 1));
         end
      end
   end

   // Called at a negedge with the engine idle (or showing done).
   task automatic start_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      bus.start  = 1'b1;
      bus.a_word = a;
      bus.b_word = b;
      e.exp  = (a >= b);
      e.scyc = cyc + 1;
      sbq.push_back(e);
`ifdef CELDA_PARALLEL_CHAIN_EN
      #1;
      check("chain", 32'(bus.result_comb), 32'(a >= b));
`endif
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3 * W + 10; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", 3 * W + 10);
   endtask

   logic [W-1:0] da [8] = '{8'h5A, 8'h80, 8'h7F, 8'h01, 8'h00, 8'hFF, 8'h00, 8'hFF};
   logic [W-1:0] db [8] = '{8'h5A, 8'h7F, 8'h80, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'h00};

   initial begin
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.a_word = '0;
      bus.b_word = '0;
      p = 1'b0; Ai = 1'b0; Bi = 1'b0;

      // Cell truth table; rst wiggles to show it has no influence.
      for (int pv = 0; pv < 2; pv++) begin
         for (int ab = 0; ab < 4; ab++) begin
            logic ea;
            p   = pv[0];
            Ai  = ab[1];
            Bi  = ab[0];
            rst = $urandom_range(0, 1);
            #20;
            ea = (Ai > Bi) ? 1'b1 : (Ai < Bi) ? 1'b0 : p;
            check("cell", 32'(P), 32'(ea));
         end
      end

      // Reset state
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_result", 32'(bus.result), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // Directed words, issued back-to-back on each done
      for (int i = 0; i < 8; i++) begin
         start_cmp(da[i], db[i]);
         wait_done();
      end
      repeat (3) @(negedge clk);

      // start while busy is ignored; the cell stays live meanwhile
      start_cmp(8'hFF, 8'h00);
      repeat (2) @(negedge clk);
      bus.start  = 1'b1;
      bus.a_word = 8'h00;
      bus.b_word = 8'hFF;
      p = 1'b1; Ai = 1'b0; Bi = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_mid", 32'(bus.busy), 32'd1);
      check("cell_live", 32'(P), 32'd0);
      wait_done();
      repeat (W + 4) @(negedge clk);

      // Reset three cycles into RUN aborts without a done pulse
      start_cmp(8'h00, 8'hFF);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      void'(sbq.pop_back());
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_result", 32'(bus.result), 32'd1);
      repeat (W + 4) @(negedge clk);
      start_cmp(8'h01, 8'h02);
      wait_done();

      // Random pairs, mostly back-to-back with occasional idle gaps
      for (int i = 0; i < 256; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = (($urandom & 7) == 0) ? ra : W'($urandom);
         start_cmp(ra, rb);
         wait_done();
         if (($urandom & 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (W + 4) @(negedge clk);
      check("sb_empty", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
